boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_sequencer.sv | 131 +++++++++++++
 tb/tb_boot_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// Boot image loader: receives a little-endian length header and data words over
// a byte stream, writes them to memory, holds the CPU in reset, then hands the bus over.
module boot_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned MAX_WORDS  = 1024,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        rxReady,
  input  logic        bootRequest,
  output logic        cpuReset,
  input  logic [31:0] cpuAddress,
  input  logic [31:0] cpuDataOut,
  input  logic        cpuWriteEnable,
  output logic [31:0] memAddress,
  output logic [31:0] memDataOut,
  output logic        memWriteEnable,
  output logic        busy,
  output logic        error
);

  localparam int unsigned W = 32;

  typedef enum logic [2:0] {
    S_HEADER,
    S_LOAD,
    S_WRITE,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t         state;
  logic [1:0]     byte_cnt;
  logic [W-1:0]   word;
  logic [W-1:0]   n_words;
  logic [W-1:0]   index;
  logic [W-1:0]   hold_cnt;

  logic           rx_fire;
  logic           in_run;
  logic [W-1:0]   next_word;
  logic [W-1:0]   load_sum;
  logic [W-1:0]   load_addr;

  assign rx_fire   = rxValid && rxReady;
  assign in_run    = (state == S_RUN) && !reset;
  // Bytes shift in from the top so the first byte ends up in bits [7:0].
  assign next_word = {rxData, word[W-1:8]};
  assign load_sum  = BASE_ADDR + {index[W-3:0], 2'b00};
  assign load_addr = {load_sum[W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_HEADER;
      byte_cnt <= 2'd0;
      word     <= '0;
      n_words  <= '0;
      index    <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_HEADER: begin
          if (rx_fire) begin
            word     <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              n_words  <= next_word;
              index    <= '0;
              hold_cnt <= '0;
              if (next_word == '0)
                state <= S_HOLD;
              else if (next_word > W'(MAX_WORDS))
                state <= S_ERROR;
              else
                state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (rx_fire) begin
            word     <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3)
              state <= S_WRITE;
          end
        end
        S_WRITE: begin
          index <= index + W'(1);
          if ((index + W'(1)) == n_words) begin
            hold_cnt <= '0;
            state    <= S_HOLD;
          end else begin
            state <= S_LOAD;
          end
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt + W'(1);
          if ((hold_cnt + W'(1)) >= W'(RESET_HOLD))
            state <= S_RUN;
        end
        S_RUN: begin
          if (bootRequest) begin
            state    <= S_HEADER;
            byte_cnt <= 2'd0;
            word     <= '0;
            n_words  <= '0;
            index    <= '0;
          end
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_HEADER;
      endcase
    end
  end

  // Status decode; reset overrides so outputs are safe before the first edge.
  assign rxReady  = !reset && ((state == S_HEADER) || (state == S_LOAD));
  assign cpuReset = !in_run;
  assign busy     = !in_run;
  assign error    = !reset && (state == S_ERROR);

  // In RUN the CPU owns the memory bus with no added latency.
  assign memWriteEnable = in_run ? cpuWriteEnable : (!reset && (state == S_WRITE));
  assign memAddress     = in_run ? cpuAddress     : load_addr;
  assign memDataOut     = in_run ? cpuDataOut     : word;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: image builder + expected-write scoreboard,
// a per-cycle bus monitor, and literal checks on key observed values.
module tb_boot_sequencer;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 1024;
  localparam int unsigned HOLD = 4;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic        rxReady;
  logic        bootRequest = 1'b0;
  logic        cpuReset;
  logic [31:0] cpuAddress = 32'h0;
  logic [31:0] cpuDataOut = 32'h0;
  logic        cpuWriteEnable = 1'b0;
  logic [31:0] memAddress;
  logic [31:0] memDataOut;
  logic        memWriteEnable;
  logic        busy;
  logic        error;

  boot_sequencer #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW),
    .RESET_HOLD(HOLD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rxData        (rxData),
    .rxValid       (rxValid),
    .rxReady       (rxReady),
    .bootRequest   (bootRequest),
    .cpuReset      (cpuReset),
    .cpuAddress    (cpuAddress),
    .cpuDataOut    (cpuDataOut),
    .cpuWriteEnable(cpuWriteEnable),
    .memAddress    (memAddress),
    .memDataOut    (memDataOut),
    .memWriteEnable(memWriteEnable),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  wr_t  exp_q[$];
  wr_t  log_q[$];
  wr_t  mon_w;
  logic prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle bus monitor; writes outside RUN are scored against exp_q in order.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      check("rst_rxready", 32'(rxReady), 32'd0);
      check("rst_memwe",   32'(memWriteEnable), 32'd0);
      check("rst_cpureset", 32'(cpuReset), 32'd1);
      check("rst_busy",    32'(busy), 32'd1);
      check("rst_error",   32'(error), 32'd0);
    end else begin
      check("busy_vs_cpureset", 32'(busy), 32'(cpuReset));
      if (!busy) begin
        check("run_addr",  memAddress, cpuAddress);
        check("run_data",  memDataOut, cpuDataOut);
        check("run_we",    32'(memWriteEnable), 32'(cpuWriteEnable));
        check("run_rxready", 32'(rxReady), 32'd0);
        check("run_error", 32'(error), 32'd0);
      end else begin
        check("boot_addr_aligned", 32'(memAddress[1:0]), 32'd0);
        if (memWriteEnable) begin
          check("write_rxready", 32'(rxReady), 32'd0);
          check("write_single_pulse", 32'(prev_we), 32'd0);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none (t=%0t)",
                     memAddress, memDataOut, $time);
          end else begin
            mon_w = exp_q.pop_front();
            check("write_addr", memAddress, mon_w.addr);
            check("write_data", memDataOut, mon_w.data);
          end
          mon_w.addr = memAddress;
          mon_w.data = memDataOut;
          log_q.push_back(mon_w);
        end
      end
      if (error) begin
        check("err_cpureset", 32'(cpuReset), 32'd1);
        check("err_rxready",  32'(rxReady), 32'd0);
        check("err_memwe",    32'(memWriteEnable), 32'd0);
      end
    end
    prev_we = !reset && busy && memWriteEnable;
  end

  // Image model: little-endian header N followed by little-endian words.
  task automatic make_image(input logic [31:0] n, input word_q_t words, output byte_q_t img);
    img = {};
    for (int b = 0; b < 4; b++) img.push_back(8'(n >> (8 * b)));
    foreach (words[i])
      for (int b = 0; b < 4; b++) img.push_back(8'(words[i] >> (8 * b)));
  endtask

  task automatic push_expected(input word_q_t words);
    wr_t w;
    foreach (words[i]) begin
      w.addr = BASE + 32'(i) * 32'd4;
      w.data = words[i];
      exp_q.push_back(w);
    end
  endtask

  // Present one byte after gap idle cycles; leaves it valid until the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      rxValid = 1'b0;
      rxData  = 8'($urandom);
    end
    @(negedge clk);
    rxValid = 1'b1;
    rxData  = b;
    n = 0;
    while (!rxReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_accept_timeout", 32'(n), 32'd0);
  endtask

  // gap < 0 selects a random gap of 0..2 per byte.
  task automatic send_range(input byte_q_t img, input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++)
      send_byte(img[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
  endtask

  // Count cycles from the last accepted byte until the CPU is released.
  task automatic wait_run(input int exp_cycles, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      rxValid = 1'b0;
      n++;
    end while (busy && n < 100);
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  task automatic pulse_boot_request();
    @(negedge clk);
    rxValid     = 1'b0;
    bootRequest = 1'b1;
    @(negedge clk);
    bootRequest = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rxValid = 1'b0;
    reset   = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_rxready", 32'(rxReady), 32'd1);
    check("post_rst_addr",    memAddress, BASE);
    check("post_rst_data",    memDataOut, 32'd0);
    check("post_rst_busy",    32'(busy), 32'd1);
    check("post_rst_error",   32'(error), 32'd0);
    check("post_rst_memwe",   32'(memWriteEnable), 32'd0);
  endtask

  task automatic check_037_log(input string tag);
    check({tag, "_nwrites"}, 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check({tag, "_w0_addr"}, log_q[0].addr, 32'h0000_0000);
      check({tag, "_w0_data"}, log_q[0].data, 32'h0000_0013);
      check({tag, "_w1_addr"}, log_q[1].addr, 32'h0000_0004);
      check({tag, "_w1_data"}, log_q[1].data, 32'hDEAD_BEEF);
    end
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t img, img037;
    word_q_t w037, wbig, wnone;
    w037  = '{32'h0000_0013, 32'hDEAD_BEEF};
    wnone = {};
    make_image(32'd2, w037, img037);

    // Reset behaviour and first cycle after release
    repeat (3) @(negedge clk);
    do_reset(2);

    // Basic two-word image, back-to-back bytes (a byte is held valid through WRITE)
    log_q = {};
    push_expected(w037);
    send_range(img037, 0, img037.size(), 0);
    wait_run(HOLD + 2, "hold_len_basic");
    check_037_log("basic");
    check("basic_error", 32'(error), 32'd0);

    // CPU passthrough in RUN, then a reboot request with a write in the same cycle
    @(negedge clk);
    cpuAddress = 32'h0000_001C; cpuDataOut = 32'h0000_0030; cpuWriteEnable = 1'b1;
    #1;
    check("run_lit_addr", memAddress, 32'h0000_001C);
    check("run_lit_data", memDataOut, 32'h0000_0030);
    check("run_lit_we",   32'(memWriteEnable), 32'd1);
    check("run_lit_cpureset", 32'(cpuReset), 32'd0);
    @(negedge clk);
    bootRequest = 1'b1; cpuAddress = 32'h0000_0020; cpuDataOut = 32'h0000_0055;
    #1;
    check("bootreq_cycle_addr", memAddress, 32'h0000_0020);
    check("bootreq_cycle_we",   32'(memWriteEnable), 32'd1);
    @(negedge clk);
    bootRequest = 1'b0;
    cpuAddress  = 32'hFFFF_FFF0;
    #1;
    check("reboot_cpureset", 32'(cpuReset), 32'd1);
    check("reboot_rxready",  32'(rxReady), 32'd1);
    check("reboot_memwe",    32'(memWriteEnable), 32'd0);
    check("reboot_addr",     memAddress, BASE);

    // Gapped stream with CPU writes active and a stray bootRequest mid-image
    log_q = {};
    push_expected(w037);
    send_range(img037, 0, 6, 3);
    pulse_boot_request();
    send_range(img037, 6, img037.size(), 3);
    wait_run(HOLD + 2, "hold_len_gapped");
    check_037_log("gapped");
    cpuWriteEnable = 1'b0;

    // Zero-length image goes straight to HOLD
    pulse_boot_request();
    log_q = {};
    make_image(32'd0, wnone, img);
    send_range(img, 0, img.size(), 0);
    wait_run(HOLD + 1, "hold_len_empty");
    check("empty_nwrites", 32'(log_q.size()), 32'd0);

    // Reset mid-word, then a full resend produces exactly the original writes
    pulse_boot_request();
    log_q = {};
    send_range(img037, 0, 6, 0);
    do_reset(2);
    push_expected(w037);
    send_range(img037, 0, img037.size(), 1);
    wait_run(HOLD + 2, "hold_len_resend");
    check_037_log("resend");

    // Largest legal image with random gaps
    do_reset(1);
    log_q = {};
    wbig = {};
    for (int i = 0; i < int'(MAXW); i++) wbig.push_back($urandom);
    make_image(32'(MAXW), wbig, img);
    push_expected(wbig);
    send_range(img, 0, img.size(), -1);
    wait_run(HOLD + 2, "hold_len_max");
    check("max_nwrites", 32'(log_q.size()), 32'(MAXW));
    if (log_q.size() == MAXW) check("max_last_addr", log_q[MAXW-1].addr, 32'h0000_0FFC);
    check("max_exp_left", 32'(exp_q.size()), 32'd0);

    // Oversized header: sticky error, nothing consumed, bootRequest ignored
    do_reset(1);
    log_q = {};
    img = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_range(img, 0, 4, 0);
    @(negedge clk);
    rxValid = 1'b0;
    #1;
    check("err_flag",        32'(error), 32'd1);
    check("err_cpureset_lit", 32'(cpuReset), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rxValid     = 1'b1;
      rxData      = 8'($urandom);
      bootRequest = (i == 3);
      #1;
      check("err_hold_rxready", 32'(rxReady), 32'd0);
      check("err_hold_flag",    32'(error), 32'd1);
    end
    @(negedge clk);
    rxValid = 1'b0; bootRequest = 1'b0;
    check("err_nwrites", 32'(log_q.size()), 32'd0);
    do_reset(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
